// File: rtl/event_order_pkg.sv
// rtl/event_order_pkg.sv - shared types and helpers for the event order checker
package event_order_pkg;

   typedef enum logic [1:0] {
      FC_NONE  = 2'b00,
      FC_ORDER = 2'b01,
      FC_TMO   = 2'b10,
      FC_CFG   = 2'b11
   } fail_code_e;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      PASS,
      FAIL
   } state_e;

   // Channel index width, kept at least one bit so a single-channel build still elaborates.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/event_order_checker_if.sv
// rtl/event_order_checker_if.sv - event, configuration and status bundle of the checker
interface event_order_checker_if #(
   parameter int N_EVT   = 4,
   parameter int SEQ_LEN = 4,
   parameter int TMO_W   = 16
);
   import event_order_pkg::*;

   localparam int IDX_W  = idx_width(N_EVT);
   localparam int STEP_W = $clog2(SEQ_LEN + 1);

   logic [N_EVT-1:0]         evt_i;
   logic [N_EVT*IDX_W-1:0]   cfg_map;
   logic [SEQ_LEN*IDX_W-1:0] cfg_seq;
   logic [STEP_W-1:0]        cfg_len;
   logic [TMO_W-1:0]         cfg_timeout;
   logic                     start_i;

   logic                     busy_o;
   logic [STEP_W-1:0]        step_o;
   logic                     done_o;
   logic                     pass_o;
   logic                     fail_o;
   fail_code_e               fail_code_o;
   logic [STEP_W-1:0]        fail_step_o;

   modport master (
      output evt_i, cfg_map, cfg_seq, cfg_len, cfg_timeout, start_i,
      input  busy_o, step_o, done_o, pass_o, fail_o, fail_code_o, fail_step_o
   );

   modport slave (
      input  evt_i, cfg_map, cfg_seq, cfg_len, cfg_timeout, start_i,
      output busy_o, step_o, done_o, pass_o, fail_o, fail_code_o, fail_step_o
   );

endinterface

// File: rtl/event_merge_map.sv
// rtl/event_merge_map.sv - folds raw event lines onto logical channels by OR-reduction
module event_merge_map
   import event_order_pkg::*;
#(
   parameter int N_EVT = 4,
   localparam int IDX_W = idx_width(N_EVT)
) (
   input  logic [N_EVT-1:0]       evt,
   input  logic [N_EVT*IDX_W-1:0] map,
   output logic [N_EVT-1:0]       logical
);

   always_comb begin
      logical = '0;
      for (int j = 0; j < N_EVT; j++) begin
         for (int i = 0; i < N_EVT; i++) begin
            if (map[i*IDX_W +: IDX_W] == IDX_W'(j)) begin
               logical[j] = logical[j] | evt[i];
            end
         end
      end
   end

endmodule

// File: rtl/event_order_checker.sv
// rtl/event_order_checker.sv - checks that event pulses arrive in a programmed order
module event_order_checker
   import event_order_pkg::*;
#(
   parameter int N_EVT   = 4,
   parameter int SEQ_LEN = 4,
   parameter int TMO_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   event_order_checker_if.slave  bus
);

   localparam int IDX_W  = idx_width(N_EVT);
   localparam int STEP_W = $clog2(SEQ_LEN + 1);

   state_e                 state, state_d;
   logic [N_EVT*IDX_W-1:0] map_q, map_d;
   logic [IDX_W-1:0]       seq_q [SEQ_LEN];
   logic [IDX_W-1:0]       seq_d [SEQ_LEN];
   logic [STEP_W-1:0]      len_q, len_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic [STEP_W-1:0]      step_q, step_d;
   logic [TMO_W-1:0]       timer_q, timer_d;
   logic                   pass_q, pass_d;
   logic                   fail_q, fail_d;
   logic                   done_q, done_d;
   fail_code_e             code_q, code_d;
   logic [STEP_W-1:0]      fstep_q, fstep_d;

   logic [N_EVT-1:0]       logical;
   logic [N_EVT-1:0]       relevant;
   logic [N_EVT-1:0]       others;
   logic [IDX_W-1:0]       exp_ch;
   logic                   len_ok;
   logic                   tmo_hit;

   event_merge_map #(.N_EVT(N_EVT)) u_merge (
      .evt     (bus.evt_i),
      .map     (map_q),
      .logical (logical)
   );

   // Channels outside the programmed prefix are don't-care; already-consumed ones stay relevant.
   always_comb begin
      relevant = '0;
      exp_ch   = '0;
      for (int k = 0; k < SEQ_LEN; k++) begin
         if (STEP_W'(k) < len_q) begin
            relevant[seq_q[k]] = 1'b1;
         end
         if (STEP_W'(k) == step_q) begin
            exp_ch = seq_q[k];
         end
      end
      others         = logical & relevant;
      others[exp_ch] = 1'b0;
   end

   assign len_ok  = (bus.cfg_len != '0) && (bus.cfg_len <= STEP_W'(SEQ_LEN));
   assign tmo_hit = (tmo_q != '0) &&
                    (({1'b0, timer_q} + (TMO_W+1)'(1)) == {1'b0, tmo_q});

   always_comb begin
      state_d = state;
      map_d   = map_q;
      seq_d   = seq_q;
      len_d   = len_q;
      tmo_d   = tmo_q;
      step_d  = step_q;
      timer_d = timer_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      code_d  = code_q;
      fstep_d = fstep_q;
      done_d  = 1'b0;

      if (bus.start_i) begin
         map_d = bus.cfg_map;
         for (int k = 0; k < SEQ_LEN; k++) begin
            seq_d[k] = bus.cfg_seq[k*IDX_W +: IDX_W];
         end
         len_d   = bus.cfg_len;
         tmo_d   = bus.cfg_timeout;
         step_d  = '0;
         timer_d = '0;
         pass_d  = 1'b0;
         fail_d  = 1'b0;
         code_d  = FC_NONE;
         fstep_d = '0;
         if (len_ok) begin
            state_d = ARMED;
         end else begin
            state_d = FAIL;
            fail_d  = 1'b1;
            code_d  = FC_CFG;
            done_d  = 1'b1;
         end
      end else if (state == ARMED) begin
         if (|others) begin
            state_d = FAIL;
            fail_d  = 1'b1;
            code_d  = FC_ORDER;
            fstep_d = step_q;
            done_d  = 1'b1;
         end else if (logical[exp_ch]) begin
            step_d  = step_q + STEP_W'(1);
            timer_d = '0;
            if ((step_q + STEP_W'(1)) == len_q) begin
               state_d = PASS;
               pass_d  = 1'b1;
               done_d  = 1'b1;
            end
         end else begin
            // Saturate so a disabled timeout never wraps back into a false hit.
            if (timer_q != '1) begin
               timer_d = timer_q + TMO_W'(1);
            end
            if (tmo_hit) begin
               state_d = FAIL;
               fail_d  = 1'b1;
               code_d  = FC_TMO;
               fstep_d = step_q;
               done_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         map_q   <= '0;
         len_q   <= '0;
         tmo_q   <= '0;
         step_q  <= '0;
         timer_q <= '0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         done_q  <= 1'b0;
         code_q  <= FC_NONE;
         fstep_q <= '0;
         for (int k = 0; k < SEQ_LEN; k++) begin
            seq_q[k] <= '0;
         end
      end else begin
         state   <= state_d;
         map_q   <= map_d;
         len_q   <= len_d;
         tmo_q   <= tmo_d;
         step_q  <= step_d;
         timer_q <= timer_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         done_q  <= done_d;
         code_q  <= code_d;
         fstep_q <= fstep_d;
         for (int k = 0; k < SEQ_LEN; k++) begin
            seq_q[k] <= seq_d[k];
         end
      end
   end

   assign bus.busy_o      = (state == ARMED);
   assign bus.step_o      = step_q;
   assign bus.done_o      = done_q;
   assign bus.pass_o      = pass_q;
   assign bus.fail_o      = fail_q;
   assign bus.fail_code_o = code_q;
   assign bus.fail_step_o = fstep_q;

endmodule

// File: tb/tb_event_order_checker.sv
// tb/tb_event_order_checker.sv - directed and randomized checks against a trace-level model
module tb_event_order_checker;
   import event_order_pkg::*;

   localparam int N_EVT   = 4;
   localparam int SEQ_LEN = 4;
   localparam int TMO_W   = 16;
   localparam int IDX_W   = 2;
   localparam int STEP_W  = 3;
   localparam int MAXC    = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   event_order_checker_if #(.N_EVT(N_EVT), .SEQ_LEN(SEQ_LEN), .TMO_W(TMO_W)) bus ();

   event_order_checker #(.N_EVT(N_EVT), .SEQ_LEN(SEQ_LEN), .TMO_W(TMO_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;

   int m_map [N_EVT];
   int m_seq [SEQ_LEN];
   int m_len;
   int m_tmo;
   logic [N_EVT-1:0] start_evt;
   logic [N_EVT-1:0] tr [MAXC];
   int tr_n;
   int last_dcyc;

   int e_pass, e_fail, e_code, e_step, e_fstep, e_done_cyc, e_busy;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // Replays the cycle trace against the ordering rules; done cycle -1 means right after start.
   task automatic model();
      int step, tmr, ex;
      bit over;
      bit [N_EVT-1:0] ch, rel, other;
      e_pass = 0; e_fail = 0; e_code = 0; e_step = 0; e_fstep = 0;
      e_done_cyc = -2; e_busy = 0;
      if (m_len < 1 || m_len > SEQ_LEN) begin
         e_fail = 1; e_code = 3; e_done_cyc = -1;
         return;
      end
      step = 0; tmr = 0; over = 0;
      rel = '0;
      for (int k = 0; k < m_len; k++) rel[m_seq[k]] = 1'b1;
      for (int c = 0; c < tr_n; c++) begin
         if (!over) begin
            ch = '0;
            for (int i = 0; i < N_EVT; i++) if (tr[c][i]) ch[m_map[i]] = 1'b1;
            ex = m_seq[step];
            other = ch & rel;
            other[ex] = 1'b0;
            if (other != 0) begin
               over = 1; e_fail = 1; e_code = 1; e_fstep = step; e_done_cyc = c;
            end else if (ch[ex]) begin
               step++; tmr = 0;
               if (step == m_len) begin
                  over = 1; e_pass = 1; e_done_cyc = c;
               end
            end else begin
               tmr++;
               if (m_tmo != 0 && tmr == m_tmo) begin
                  over = 1; e_fail = 1; e_code = 2; e_fstep = step; e_done_cyc = c;
               end
            end
         end
      end
      e_step = step;
      e_busy = over ? 0 : 1;
   endtask

   task automatic run_check(input string name);
      logic [N_EVT*IDX_W-1:0]   mp;
      logic [SEQ_LEN*IDX_W-1:0] sq;
      int dcnt, dcyc;
      dcnt = 0; dcyc = -2;
      for (int i = 0; i < N_EVT; i++)   mp[i*IDX_W +: IDX_W] = IDX_W'(m_map[i]);
      for (int k = 0; k < SEQ_LEN; k++) sq[k*IDX_W +: IDX_W] = IDX_W'(m_seq[k]);
      model();
      @(negedge clk);
      bus.cfg_map     = mp;
      bus.cfg_seq     = sq;
      bus.cfg_len     = STEP_W'(m_len);
      bus.cfg_timeout = TMO_W'(m_tmo);
      bus.start_i     = 1'b1;
      bus.evt_i       = start_evt;
      @(negedge clk);
      bus.start_i = 1'b0;
      if (bus.done_o) begin dcnt++; dcyc = -1; end
      check_val({name, "/step_clr"}, int'(bus.step_o), 0);
      for (int c = 0; c < tr_n; c++) begin
         bus.evt_i = tr[c];
         @(negedge clk);
         if (bus.done_o) begin
            dcnt++;
            if (dcyc == -2) dcyc = c;
         end
      end
      bus.evt_i = '0;
      last_dcyc = dcyc;
      check_val({name, "/done_cnt"}, dcnt, (e_done_cyc == -2) ? 0 : 1);
      check_val({name, "/done_cyc"}, dcyc, e_done_cyc);
      check_val({name, "/pass"}, int'(bus.pass_o), e_pass);
      check_val({name, "/fail"}, int'(bus.fail_o), e_fail);
      check_val({name, "/code"}, int'(bus.fail_code_o), e_code);
      check_val({name, "/step"}, int'(bus.step_o), e_step);
      check_val({name, "/fstep"}, int'(bus.fail_step_o), e_fstep);
      check_val({name, "/busy"}, int'(bus.busy_o), e_busy);
   endtask

   task automatic set_identity();
      for (int i = 0; i < N_EVT; i++) m_map[i] = i;
   endtask

   task automatic clear_trace(input int n);
      tr_n = n;
      for (int c = 0; c < MAXC; c++) tr[c] = '0;
   endtask

   task automatic check_all_zero(input string name);
      check_val({name, "/busy"}, int'(bus.busy_o), 0);
      check_val({name, "/step"}, int'(bus.step_o), 0);
      check_val({name, "/done"}, int'(bus.done_o), 0);
      check_val({name, "/pass"}, int'(bus.pass_o), 0);
      check_val({name, "/fail"}, int'(bus.fail_o), 0);
      check_val({name, "/code"}, int'(bus.fail_code_o), 0);
      check_val({name, "/fstep"}, int'(bus.fail_step_o), 0);
   endtask

   initial begin
      rst             = 1'b1;
      bus.evt_i       = '0;
      bus.cfg_map     = '0;
      bus.cfg_seq     = '0;
      bus.cfg_len     = '0;
      bus.cfg_timeout = '0;
      bus.start_i     = 1'b0;
      start_evt       = '0;
      m_tmo           = 0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // In-order pass with events in the start cycle that must be ignored
      set_identity();
      m_seq = '{0, 1, 2, 3}; m_len = 3; m_tmo = 0; start_evt = 4'b0010;
      clear_trace(11);
      tr[1] = 4'b0001; tr[4] = 4'b0010; tr[8] = 4'b0100;
      run_check("inorder");
      check_val("inorder/done_at", last_dcyc, 8);
      start_evt = '0;

      clear_trace(5);
      tr[0] = 4'b0001; tr[2] = 4'b0100;
      run_check("outoforder");

      m_map = '{0, 0, 2, 3}; m_seq = '{0, 0, 2, 3}; m_len = 3;
      clear_trace(6);
      tr[0] = 4'b0001; tr[1] = 4'b0010; tr[3] = 4'b0100;
      run_check("merge_pass");
      clear_trace(5);
      tr[0] = 4'b0011; tr[2] = 4'b0100;
      run_check("merge_single");

      set_identity();
      m_seq = '{0, 1, 2, 3}; m_len = 2; m_tmo = 5;
      clear_trace(9);
      tr[0] = 4'b0001;
      run_check("timeout");
      check_val("timeout/done_at", last_dcyc, 5);
      m_tmo = 0;

      m_len = 3;
      clear_trace(3);
      tr[0] = 4'b0011;
      run_check("simul");
      clear_trace(8);
      tr[0] = 4'b1000; tr[1] = 4'b0001; tr[2] = 4'b1000;
      tr[3] = 4'b0010; tr[4] = 4'b1000; tr[5] = 4'b0100;
      run_check("ignore_e3");

      // Leave the checker armed, then restart it mid-check with a new sequence
      clear_trace(2);
      tr[0] = 4'b0001;
      run_check("arm");
      m_seq = '{3, 2, 0, 0}; m_len = 2;
      clear_trace(4);
      tr[0] = 4'b1000; tr[1] = 4'b0100;
      run_check("rearm");

      m_len = 0;
      clear_trace(3);
      run_check("len0");
      m_len = 5;
      run_check("len5");

      m_seq = '{0, 1, 2, 3}; m_len = 3;
      clear_trace(2);
      tr[0] = 4'b0001;
      run_check("pre_rst");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("mid_rst");
      rst = 1'b0;

      for (int it = 0; it < 40; it++) begin
         int nstep, gap, pick, off, idx, ev;
         for (int i = 0; i < N_EVT; i++)   m_map[i] = $urandom_range(0, N_EVT-1);
         for (int k = 0; k < SEQ_LEN; k++) m_seq[k] = $urandom_range(0, N_EVT-1);
         if ($urandom_range(0, 9) == 0) m_len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(5, 7);
         else m_len = $urandom_range(1, SEQ_LEN);
         m_tmo = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(2, 8);
         start_evt = N_EVT'($urandom_range(0, 15));
         clear_trace(0);
         nstep = (m_len > SEQ_LEN) ? SEQ_LEN : m_len;
         for (int k = 0; k < nstep; k++) begin
            gap = $urandom_range(0, 6);
            tr_n += gap;
            pick = -1;
            off = $urandom_range(0, N_EVT-1);
            for (int j = 0; j < N_EVT; j++) begin
               idx = (off + j) % N_EVT;
               if (pick < 0 && m_map[idx] == m_seq[k]) pick = idx;
            end
            if (pick < 0) pick = $urandom_range(0, N_EVT-1);
            ev = 1 << pick;
            if ($urandom_range(0, 7) == 0) ev = $urandom_range(1, 15);
            tr[tr_n] = N_EVT'(ev);
            tr_n++;
         end
         tr_n += 3;
         run_check($sformatf("rand%0d", it));
      end
      start_evt = '0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
